five4add_driver: RTL and testbench

//  Clocked initiator for the five-operand 4-bit adder's push-button load interface.
//  On start, drives Y and strobes PB[0..3], then RPB, in order, to load operands A..E.

---
 rtl/five4add_driver.sv | 124 ++++++++++++
 tb/tb_five4add_driver.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/five4add_driver.sv
// Sequencer that loads operands A..E into the five-operand adder through its
// push-button strobe interface, then captures and checks the settled sum.
module five4add_driver #(
    parameter int W          = 4,
    parameter int SETUP_CYC  = 1,
    parameter int PULSE_CYC  = 2,
    parameter int SETTLE_CYC = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   op_a,
    input  logic [W-1:0]   op_b,
    input  logic [W-1:0]   op_c,
    input  logic [W-1:0]   op_d,
    input  logic [W-1:0]   op_e,
    input  logic [W+2:0]   sum_in,
    output logic [3:0]     PB,
    output logic           RPB,
    output logic [W-1:0]   Y,
    output logic           busy,
    output logic           done,
    output logic [W+2:0]   result,
    output logic           mismatch
);

    localparam int SW = W + 3;

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, SETTLE, CAPTURE} state_t;

    state_t         state;
    logic [7:0]     cnt;
    logic [2:0]     k;
    logic [W-1:0]   ops [5];
    logic [SW-1:0]  expected;

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values; blocking writes would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            k        <= '0;
            // NOTE: the operand copy is a handful of flops, not a RAM, so it is
            // reset along with everything else to keep it free of X after reset.
            for (int i = 0; i < 5; i++) ops[i] <= '0;
            expected <= '0;
            PB       <= '0;
            RPB      <= 1'b0;
            Y        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            mismatch <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ops[0]   <= op_a;
                        ops[1]   <= op_b;
                        ops[2]   <= op_c;
                        ops[3]   <= op_d;
                        ops[4]   <= op_e;
                        expected <= SW'(op_a) + SW'(op_b) + SW'(op_c) + SW'(op_d) + SW'(op_e);
                        k        <= '0;
                        cnt      <= '0;
                        Y        <= op_a;
                        busy     <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == 8'(SETUP_CYC - 1)) begin
                        cnt <= '0;
                        // Operands A..D use PB[k]; E has its own strobe.
                        if (k == 3'd4) RPB <= 1'b1;
                        else           PB  <= 4'b0001 << k[1:0];
                        state <= STROBE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                STROBE: begin
                    if (cnt == 8'(PULSE_CYC - 1)) begin
                        cnt   <= '0;
                        PB    <= '0;
                        RPB   <= 1'b0;
                        state <= HOLD;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (k == 3'd4) begin
                        Y     <= '0;
                        state <= SETTLE;
                    end else begin
                        k     <= k + 3'd1;
                        Y     <= ops[k + 3'd1];
                        state <= SETUP;
                    end
                end
                SETTLE: begin
                    if (cnt == 8'(SETTLE_CYC - 1)) begin
                        cnt   <= '0;
                        state <= CAPTURE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                CAPTURE: begin
                    result   <= sum_in;
                    mismatch <= (sum_in != expected);
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_five4add_driver.sv
// Self-checking bench for five4add_driver: a strobe-latching adder model feeds
// sum_in, and each run's output trace is compared with one built from the operands.
module tb_five4add_driver;

    localparam int W  = 4;
    localparam int SW = W + 3;
    localparam int SETUP_CYC  = 1;
    localparam int PULSE_CYC  = 2;
    localparam int SETTLE_CYC = 2;
    localparam int LATENCY = 5 * (SETUP_CYC + PULSE_CYC + 1) + SETTLE_CYC + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  op_a = '0, op_b = '0, op_c = '0, op_d = '0, op_e = '0;
    logic [SW-1:0] sum_in;
    logic [3:0]    PB;
    logic          RPB;
    logic [W-1:0]  Y;
    logic          busy, done, mismatch;
    logic [SW-1:0] result;

    five4add_driver #(.W(W), .SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC),
                      .SETTLE_CYC(SETTLE_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d), .op_e(op_e),
        .sum_in(sum_in), .PB(PB), .RPB(RPB), .Y(Y),
        .busy(busy), .done(done), .result(result), .mismatch(mismatch)
    );

    always #5 clk = ~clk;

    // Adder model: each operand register latches Y while its strobe is high.
    logic [W-1:0]  m_reg [5];
    logic          force_en = 1'b0;
    logic [SW-1:0] force_val = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) m_reg[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) if (PB[i]) m_reg[i] <= Y;
            if (RPB) m_reg[4] <= Y;
        end
    end

    always_comb begin
        sum_in = SW'(m_reg[0]) + SW'(m_reg[1]) + SW'(m_reg[2]) + SW'(m_reg[3]) + SW'(m_reg[4]);
        if (force_en) sum_in = force_val;
    end

    int oh_bad = 0;
    always @(negedge clk) if (!$onehot0({RPB, PB})) oh_bad++;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic randomize_ops();
        op_a = W'($urandom); op_b = W'($urandom); op_c = W'($urandom);
        op_d = W'($urandom); op_e = W'($urandom);
    endtask

    // One full sequence: trace entry i is {busy,RPB,PB,Y} sampled i cycles after the start edge.
    task automatic run_seq(input string tag, input logic [W-1:0] o [5],
                           input bit fe, input logic [SW-1:0] fv, input bit poke);
        logic [9:0]    got [$];
        logic [9:0]    exp_q [$];
        logic [3:0]    pbv;
        logic [SW-1:0] exp_sum;
        int            lat;
        int            tbad;
        force_en = fe;
        force_val = fv;
        @(negedge clk);
        op_a = o[0]; op_b = o[1]; op_c = o[2]; op_d = o[3]; op_e = o[4];
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
            got.push_back({busy, RPB, PB, Y});
            start = poke && (i == 3 || i == 10);
            randomize_ops();
        end
        start = 1'b0;
        check($sformatf("%s latency", tag), lat, LATENCY);

        exp_sum = '0;
        for (int k = 0; k < 5; k++) begin
            exp_sum += SW'(o[k]);
            pbv = (k < 4) ? 4'(1 << k) : 4'b0000;
            repeat (SETUP_CYC) exp_q.push_back({1'b1, 1'b0, 4'b0000, o[k]});
            repeat (PULSE_CYC) exp_q.push_back({1'b1, k == 4, pbv, o[k]});
            exp_q.push_back({1'b1, 1'b0, 4'b0000, o[k]});
        end
        repeat (SETTLE_CYC + 1) exp_q.push_back({1'b1, 1'b0, 4'b0000, {W{1'b0}}});

        tbad = (got.size() == exp_q.size()) ? 0 : 1;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            if (got[i] !== exp_q[i]) tbad++;
        check($sformatf("%s trace", tag), tbad, 0);
        check($sformatf("%s result", tag), result, fe ? fv : exp_sum);
        check($sformatf("%s mismatch", tag), mismatch, fe ? (fv != exp_sum) : 1'b0);
        @(negedge clk);
        check($sformatf("%s done_width", tag), done, 1'b0);
        check($sformatf("%s busy_after", tag), busy, 1'b0);
        force_en = 1'b0;
    endtask

    initial begin
        logic [W-1:0] o [5];
        int lat;
        int seen;

        // Reset state
        #12;
        check("rst PB", PB, 0);
        check("rst RPB", RPB, 0);
        check("rst Y", Y, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst result", result, 0);
        check("rst mismatch", mismatch, 0);
        @(negedge clk);
        rst_n = 1'b1;

        o = '{4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
        run_seq("all9", o, 1'b0, '0, 1'b0);
        check("all9 value", result, 7'b0101101);
        o = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
        run_seq("max", o, 1'b0, '0, 1'b0);
        o = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        run_seq("zero", o, 1'b0, '0, 1'b0);
        o = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        run_seq("forced", o, 1'b1, 7'd1, 1'b0);
        o = '{4'd3, 4'd7, 4'd12, 4'd0, 4'd6};
        run_seq("poke", o, 1'b0, '0, 1'b1);
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 5; k++) o[k] = W'($urandom);
            run_seq($sformatf("rand%0d", r), o, 1'b0, '0, r[0]);
        end

        // Reset asserted during the PB[2] strobe
        @(negedge clk);
        op_a = 4'd5; op_b = 4'd6; op_c = 4'd7; op_d = 4'd8; op_e = 4'd9;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (PB == 4'b0100) begin
                seen = 1;
                break;
            end
        end
        check("midrst reached PB2", seen, 1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst PB", PB, 0);
        check("midrst Y", Y, 0);
        check("midrst busy", busy, 0);
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("midrst no done", seen, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) o[k] = W'($urandom);
        run_seq("after_rst", o, 1'b0, '0, 1'b0);

        // start held high re-triggers on the first IDLE cycle after done
        @(negedge clk);
        op_a = 4'd1; op_b = 4'd1; op_c = 4'd1; op_d = 4'd1; op_e = 4'd1;
        start = 1'b1;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        check("hold first done", lat, LATENCY);
        check("hold first result", result, 7'd5);
        op_a = 4'd2; op_b = 4'd2; op_c = 4'd2; op_d = 4'd2; op_e = 4'd2;
        @(negedge clk);
        start = 1'b0;
        check("hold retrigger busy", busy, 1);
        check("hold retrigger done", done, 0);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i + 1;
                break;
            end
        end
        check("hold second done", lat, LATENCY);
        check("hold second result", result, 7'd10);
        check("hold second mismatch", mismatch, 0);

        check("onehot strobes", oh_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
